route_sequencer: RTL and testbench
==================================

# route_sequencer

Programmable route controller that sits between the line sensors and the motion/line-follow block. It holds a host-loaded table of per-node actions and debounces node detection (all three sensors on line). At each node it issues the next action to the motion block over a valid/ready handshake and drives the electromagnet and status LEDs, ending the run on a terminal stop entry.

## Interface
- DEPTH, 16: route table entries; address width AW = clog2(DEPTH)
- DEBOUNCE, 8: consecutive adc_data==3'b111 samples that constitute a node
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe, accepted only in IDLE
- cfg_addr  in  AW  table write address
- cfg_data  in  9  entry: [8:6] action, [5:4] magnet op, [3:0] LED code
- cfg_len  in  AW+1  route length, sampled on start; 0 = start ignored
- start  in  1  one-cycle pulse, begin route at entry 0
- adc_data  in  3  sensor bits, MSB = left, 1 = line
- act_valid  out  1  action offered to motion block
- act_code  out  3  action code
- act_ready  in  1  motion block accepts action
- turn_done  in  1  motion block reports action complete, line reacquired
- elctr_o  out  1  electromagnet drive
- led  out  4  LED code of last executed entry
- pos  out  AW  current table index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on route completion

## Operation
- Action codes (existing codebase values): follow_line 000, turn_R 001, turn_L 011, go_st 110, stop_s 111. Any other code is treated as go_st.
- Magnet ops: 00 hold, 01 on, 10 off, 11 toggle.
- States: IDLE, LAUNCH, FOLLOW, ISSUE, EXEC, FINISH.
- IDLE: table writable. start with cfg_len!=0 latches len, clears pos, goes to LAUNCH.
- LAUNCH: act_code=follow_line, act_valid=1. On act_ready goes to FOLLOW; the debounce counter clears and the rearm flag clears.
- FOLLOW: the rearm flag sets on the first sample with adc_data!=111. While rearmed, the debounce counter increments on each 111 sample and clears on any other value. When the counter reaches DEBOUNCE, entry[pos] is read, the magnet op is applied, led is loaded, and the block goes to ISSUE.
- ISSUE: act_code = entry action, act_valid=1, held stable until act_ready.
  - If action is stop_s and pos==len-1: go to FINISH.
  - Otherwise: go to EXEC.
- EXEC: act_valid=0. On turn_done:
  - pos increments, wrapping to 0 after len-1.
  - Go to LAUNCH.
- FINISH: done=1 for one cycle, then IDLE. elctr_o and led are retained.
- A stop_s entry that is not the last entry behaves as a pause: EXEC waits for turn_done.
- Ignored inputs:
  - start while busy.
  - cfg_we outside IDLE.
  - turn_done outside EXEC.
  - act_ready while act_valid=0.

## Timing
- Reset values: act_valid 0, act_code 000, elctr_o 0, led 0000, pos 0, busy 0, done 0. State is IDLE, debounce counter 0, rearm 0, and table contents are undefined.
- All outputs are registered.
- start to act_valid: 1 cycle.
- Node detection: on the edge that samples the DEBOUNCE-th consecutive 111, led, elctr_o and state=ISSUE update. act_valid rises on that same edge. Total latency from first 111 sample is DEBOUNCE cycles.
- Handshake: a transfer occurs on the edge where act_valid&&act_ready. act_valid deasserts or changes code on that edge. act_code never changes while act_valid=1 and act_ready=0.
- act_ready held high permanently: LAUNCH and ISSUE each last exactly one cycle.
- turn_done and a new 111 in the same cycle: turn_done is honoured. The node is not counted because rearm is cleared in LAUNCH.
- rst mid-route drops act_valid and de-energises the magnet on the next edge.
- Table write: data is visible to the next cycle's read.

## Structure
- Package route_pkg: action code constants, magnet op constants, entry field slice constants, state enum.
- Sub-module node_debouncer: inputs clk, rst, clr, adc_data; output node_hit. Contains the counter and rearm flag.
- Table: register array of DEPTH × 9 inside route_sequencer.

## Test plan
- Program entries {turn_L,on,0001},{turn_R,off,0010},{stop_s,hold,0011}, len=3, start. Then present 111 for 8 cycles at each node and pulse turn_done. Expect act_code sequence 000,011,000,001,000,111; elctr_o 1 then 0; done pulse; led=0011; pos=2.
- Present 111 for 7 cycles, then 010, then 111 for 8 cycles. Expect exactly one node detection, on the 8th 111 sample of the second burst.
- Hold adc_data=111 through EXEC and the following LAUNCH. Expect no second detection until adc_data leaves 111 and re-enters for 8 cycles.
- len=2, entries {go_st},{turn_R}. Pass 3 nodes. Expect pos 0,1,0 (wrap) and act_codes 110,001,110.
- In ISSUE, hold act_ready=0 for 5 cycles. Expect act_valid/act_code stable, then accepted on the cycle act_ready=1.
- Assert rst in EXEC with elctr_o=1. Expect all outputs at reset values next cycle. Also: start with cfg_len=0 leaves busy=0.

Source files
------------

// File: rtl/route_pkg.sv
// Shared constants, entry layout and state encoding for the route sequencer.
package route_pkg;

    localparam logic [2:0] ACT_FOLLOW = 3'b000;
    localparam logic [2:0] ACT_TURN_R = 3'b001;
    localparam logic [2:0] ACT_TURN_L = 3'b011;
    localparam logic [2:0] ACT_GO_ST  = 3'b110;
    localparam logic [2:0] ACT_STOP   = 3'b111;

    localparam logic [1:0] MAG_HOLD   = 2'b00;
    localparam logic [1:0] MAG_ON     = 2'b01;
    localparam logic [1:0] MAG_OFF    = 2'b10;
    localparam logic [1:0] MAG_TOGGLE = 2'b11;

    localparam int ENTRY_W = 9;
    localparam int ACT_MSB = 8;
    localparam int ACT_LSB = 6;
    localparam int MAG_MSB = 5;
    localparam int MAG_LSB = 4;
    localparam int LED_MSB = 3;
    localparam int LED_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FOLLOW,
        S_ISSUE,
        S_EXEC,
        S_FINISH
    } state_t;

    // Unknown action codes fall back to go-straight.
    function automatic logic [2:0] norm_action(input logic [2:0] code);
        logic [2:0] res;
        case (code)
            ACT_FOLLOW, ACT_TURN_R, ACT_TURN_L, ACT_GO_ST, ACT_STOP: res = code;
            default: res = ACT_GO_ST;
        endcase
        return res;
    endfunction

    function automatic logic apply_magnet(input logic cur, input logic [1:0] op);
        logic res;
        case (op)
            MAG_ON:     res = 1'b1;
            MAG_OFF:    res = 1'b0;
            MAG_TOGGLE: res = ~cur;
            default:    res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/route_sequencer_if.sv
// Action handshake between the route sequencer and the motion block.
interface route_sequencer_if;

    logic       act_valid;
    logic [2:0] act_code;
    logic       act_ready;
    logic       turn_done;

    modport master (
        output act_valid,
        output act_code,
        input  act_ready,
        input  turn_done
    );

    modport slave (
        input  act_valid,
        input  act_code,
        output act_ready,
        output turn_done
    );

endinterface

// File: rtl/node_debouncer.sv
// Node detector: DEBOUNCE consecutive all-on-line samples, armed only after
// the sensors have seen something other than a full line.
module node_debouncer #(
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [2:0] adc_data,
    output logic       node_hit
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] count;
    logic          rearm;
    logic          on_line;

    assign on_line = (adc_data == 3'b111);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            rearm <= 1'b0;
        end else begin
            if (!on_line) begin
                rearm <= 1'b1;
            end
            if (rearm && on_line) begin
                if (count != CW'(DEBOUNCE)) begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    // Combinational so the owner reacts on the edge of the final sample.
    assign node_hit = rearm && on_line && (count == CW'(DEBOUNCE - 1));

endmodule

// File: rtl/route_sequencer.sv
// Route controller: steps through a host-loaded action table, one entry per
// debounced line node, handing actions to the motion block.
module route_sequencer
    import route_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int DEBOUNCE = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_data,
    input  logic [AW:0]        cfg_len,
    input  logic               start,
    input  logic [2:0]         adc_data,
    route_sequencer_if.master  act,
    output logic               elctr_o,
    output logic [3:0]         led,
    output logic [AW-1:0]      pos,
    output logic               busy,
    output logic               done
);

    state_t state;
    state_t state_n;

    logic [ENTRY_W-1:0] route_tbl [DEPTH];
    logic [AW:0]        len;
    logic [ENTRY_W-1:0] entry;
    logic [2:0]         entry_act;
    logic               last;
    logic               node_hit;
    logic               clr;

    logic [AW-1:0] pos_n;
    logic          elctr_n;
    logic [3:0]    led_n;
    logic [2:0]    act_code_n;

    assign entry     = route_tbl[pos];
    assign entry_act = norm_action(entry[ACT_MSB:ACT_LSB]);
    assign last      = ({1'b0, pos} == (len - 1'b1));
    // Holding the detector cleared outside FOLLOW guarantees a fresh rearm per node.
    assign clr       = (state != S_FOLLOW);

    node_debouncer #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .adc_data (adc_data),
        .node_hit (node_hit)
    );

    always_ff @(posedge clk) begin
        if (state == S_IDLE && cfg_we) begin
            route_tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start && cfg_len != '0) begin
            len <= cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        pos_n      = pos;
        elctr_n    = elctr_o;
        led_n      = led;
        act_code_n = act.act_code;
        case (state)
            S_IDLE: begin
                if (start && cfg_len != '0) begin
                    state_n = S_LAUNCH;
                    pos_n   = '0;
                end
            end
            S_LAUNCH: begin
                if (act.act_ready) begin
                    state_n = S_FOLLOW;
                end
            end
            S_FOLLOW: begin
                if (node_hit) begin
                    state_n = S_ISSUE;
                    elctr_n = apply_magnet(elctr_o, entry[MAG_MSB:MAG_LSB]);
                    led_n   = entry[LED_MSB:LED_LSB];
                end
            end
            S_ISSUE: begin
                if (act.act_ready) begin
                    state_n = (entry_act == ACT_STOP && last) ? S_FINISH : S_EXEC;
                end
            end
            S_EXEC: begin
                if (act.turn_done) begin
                    state_n = S_LAUNCH;
                    pos_n   = last ? '0 : pos + 1'b1;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (state_n == S_LAUNCH) begin
            act_code_n = ACT_FOLLOW;
        end else if (state_n == S_ISSUE) begin
            act_code_n = entry_act;
        end
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            act.act_valid <= 1'b0;
            act.act_code  <= ACT_FOLLOW;
            elctr_o       <= 1'b0;
            led           <= '0;
            pos           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            act.act_valid <= (state_n == S_LAUNCH) || (state_n == S_ISSUE);
            act.act_code  <= act_code_n;
            elctr_o       <= elctr_n;
            led           <= led_n;
            pos           <= pos_n;
            busy          <= (state_n != S_IDLE);
            done          <= (state_n == S_FINISH);
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Randomized bench for route_sequencer against a transaction-level route model.
module tb_route_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [8:0] cfg_data;
    logic [4:0] cfg_len;
    logic       start;
    logic [2:0] adc_data;
    logic       elctr_o;
    logic [3:0] led;
    logic [3:0] pos;
    logic       busy;
    logic       done;

    route_sequencer_if act();

    route_sequencer #(
        .DEPTH    (16),
        .DEBOUNCE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_len  (cfg_len),
        .start    (start),
        .adc_data (adc_data),
        .act      (act),
        .elctr_o  (elctr_o),
        .led      (led),
        .pos      (pos),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] m_tbl [16];
    int         m_len;
    int         m_pos;
    logic       m_mag;
    logic [3:0] m_led;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] m_act(input logic [2:0] a);
        if (a == 3'b000 || a == 3'b001 || a == 3'b011 || a == 3'b110 || a == 3'b111) return a;
        return 3'b110;
    endfunction

    function automatic logic m_magnet(input logic cur, input logic [1:0] op);
        if (op == 2'b01) return 1'b1;
        if (op == 2'b10) return 1'b0;
        if (op == 2'b11) return ~cur;
        return cur;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, act.act_valid, 0);
        chk({tag, "_code"}, act.act_code, 0);
        chk({tag, "_elctr"}, elctr_o, 0);
        chk({tag, "_led"}, led, 0);
        chk({tag, "_pos"}, pos, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        m_mag = 1'b0;
        m_led = 4'h0;
        m_pos = 0;
    endtask

    task automatic distract();
        act.turn_done = 1'($urandom_range(0, 1));
        start         = 1'($urandom_range(0, 1));
        cfg_we        = 1'($urandom_range(0, 1));
        cfg_addr      = 4'($urandom_range(0, 15));
        cfg_data      = 9'($urandom_range(0, 511));
        cfg_len       = 5'($urandom_range(1, 16));
    endtask

    task automatic quiet();
        act.turn_done = 1'b0;
        start         = 1'b0;
        cfg_we        = 1'b0;
    endtask

    task automatic handshake(input string tag, input logic [2:0] exp, input int stall);
        chk({tag, "_valid"}, act.act_valid, 1);
        chk({tag, "_code"}, act.act_code, exp);
        repeat (stall) begin
            act.act_ready = 1'b0;
            tick();
            chk({tag, "_stall_valid"}, act.act_valid, 1);
            chk({tag, "_stall_code"}, act.act_code, exp);
        end
        act.act_ready = 1'b1;
        tick();
        act.act_ready = 1'b0;
        chk({tag, "_taken"}, act.act_valid, 0);
    endtask

    // A node is 8 consecutive full-line samples preceded (within FOLLOW) by a non-full sample.
    task automatic do_node(input bit hold, input bit directed);
        int k;
        int m;
        k = hold ? $urandom_range(3, 10) : (directed ? 0 : $urandom_range(0, 3));
        repeat (k) begin
            adc_data = 3'b111;
            distract();
            tick();
            chk("hold_no_node", act.act_valid, 0);
        end
        quiet();
        repeat (directed ? 1 : $urandom_range(1, 2)) begin
            adc_data = 3'($urandom_range(0, 6));
            tick();
            chk("noise_no_node", act.act_valid, 0);
        end
        if (directed || $urandom_range(0, 1) == 1) begin
            m = directed ? 7 : $urandom_range(1, 7);
            repeat (m) begin
                adc_data = 3'b111;
                tick();
                chk("short_burst", act.act_valid, 0);
            end
            adc_data = directed ? 3'b010 : 3'($urandom_range(0, 6));
            tick();
            chk("burst_break", act.act_valid, 0);
        end
        for (int i = 0; i < 8; i++) begin
            adc_data = 3'b111;
            tick();
            if (i < 7) chk("debounce_wait", act.act_valid, 0);
        end
    endtask

    task automatic run_route(input int len, input int max_nodes, input int rst_node,
                             input int stall, input bit directed);
        bit         hold;
        logic [8:0] e;
        logic [2:0] code;
        for (int i = 0; i < len; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = m_tbl[i];
            tick();
        end
        cfg_we  = 1'b0;
        cfg_len = 5'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        m_len   = len;
        m_pos   = 0;
        hold    = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_pos", pos, 0);
        handshake("launch", 3'b000, (stall >= 0) ? stall : $urandom_range(0, 3));
        for (int n = 0; n < max_nodes; n++) begin
            do_node(hold, directed);
            e     = m_tbl[m_pos];
            m_mag = m_magnet(m_mag, e[5:4]);
            m_led = e[3:0];
            code  = m_act(e[8:6]);
            chk("node_led", led, m_led);
            chk("node_elctr", elctr_o, m_mag);
            chk("node_pos", pos, m_pos);
            handshake("issue", code, (stall >= 0) ? stall : $urandom_range(0, 5));
            if (code == 3'b111 && m_pos == m_len - 1) begin
                chk("finish_done", done, 1);
                chk("finish_busy", busy, 1);
                tick();
                chk("after_done", done, 0);
                chk("after_busy", busy, 0);
                chk("end_led", led, m_led);
                chk("end_elctr", elctr_o, m_mag);
                chk("end_pos", pos, m_pos);
                return;
            end
            if (n == rst_node || n == max_nodes - 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset("rst_exec");
                return;
            end
            hold = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
                act.act_ready = 1'($urandom_range(0, 1));
                adc_data      = hold ? 3'b111 : 3'($urandom_range(0, 7));
                tick();
                chk("exec_wait_valid", act.act_valid, 0);
                chk("exec_wait_pos", pos, m_pos);
            end
            act.act_ready = 1'b0;
            adc_data      = hold ? 3'b111 : 3'($urandom_range(0, 7));
            act.turn_done = 1'b1;
            tick();
            act.turn_done = 1'b0;
            m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
            chk("next_pos", pos, m_pos);
            handshake("relaunch", 3'b000, (stall >= 0) ? stall : $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        cfg_len       = '0;
        start         = 1'b0;
        adc_data      = 3'b000;
        act.act_ready = 1'b0;
        act.turn_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        m_tbl[0] = {3'b011, 2'b01, 4'b0001};
        m_tbl[1] = {3'b001, 2'b10, 4'b0010};
        m_tbl[2] = {3'b111, 2'b00, 4'b0011};
        run_route(3, 10, -1, 0, 1'b1);

        m_tbl[0] = {3'b110, 2'b00, 4'b0100};
        m_tbl[1] = {3'b001, 2'b00, 4'b0101};
        run_route(2, 3, -1, -1, 1'b0);

        m_tbl[0] = {3'b111, 2'b11, 4'b1111};
        run_route(1, 2, -1, 5, 1'b0);

        m_tbl[0] = {3'b001, 2'b01, 4'b0110};
        m_tbl[1] = {3'b011, 2'b00, 4'b0111};
        run_route(2, 4, 0, -1, 1'b0);

        cfg_len = '0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_valid", act.act_valid, 0);
        tick();
        chk("len0_busy_later", busy, 0);

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) m_tbl[i] = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) m_tbl[len - 1][8:6] = 3'b111;
            run_route(len, 2 * len + 1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1,
                      -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
